// File: rtl/hdmiext_tmds_rx_channel_pkg.sv
// Shared TMDS receive definitions: control-token words, FSM encoding, decoded word record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hdmiext_tmds_rx_channel_pkg;

    // 10-bit TMDS control tokens, bit 0 first on the wire
    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    // Word-alignment state machine encoding
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } rx_state_e;

    // Decoded output word
    typedef struct packed {
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
    } tmds_dec_t;

endpackage

// File: rtl/hdmiext_tmds_rx_channel_decode10.sv
// Combinational TMDS 10b->8b decode with control-token detection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluates every word presented.
module hdmiext_tmds_decode10
    import hdmiext_tmds_rx_channel_pkg::*;
(
    input  logic [9:0] raw,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [7:0] d;

    // Token match, then undo the optional inversion and the XOR/XNOR chain
    always_comb begin
        is_ctrl = 1'b1;
        ctrl    = 2'b00;
        data    = '0;
        case (raw)
            TMDS_CTRL_00: ctrl = 2'b00;
            TMDS_CTRL_01: ctrl = 2'b01;
            TMDS_CTRL_10: ctrl = 2'b10;
            TMDS_CTRL_11: ctrl = 2'b11;
            default:      is_ctrl = 1'b0;
        endcase
        d       = raw[9] ? ~raw[7:0] : raw[7:0];
        data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = raw[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

endmodule

// File: rtl/hdmiext_tmds_rx_channel.sv
// One TMDS receive lane: word alignment via bitslip search plus registered 10b->8b decode.
// Latency: de/ctrl/data 1 cycle after raw; locked/bitslip registered from the FSM next state.
// Backpressure: none; a new word is consumed every pix_clk.
module hdmiext_tmds_rx_channel
    import hdmiext_tmds_rx_channel_pkg::*;
#(
    parameter int LOCK_TOKENS   = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int SLIP_WAIT     = 4
)
(
    input  logic       pix_clk,
    input  logic       pix_rst,
    input  logic [9:0] raw,
    output logic       bitslip,
    output logic       locked,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data,
    output logic [3:0] slip_count
);

    localparam int WIN_W  = $clog2(SEARCH_WINDOW + 1);
    localparam int TOK_W  = $clog2(LOCK_TOKENS + 1);
    localparam int WAIT_W = (SLIP_WAIT < 1) ? 1 : $clog2(SLIP_WAIT + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [TOK_W-1:0]  TOK_LOCK  = TOK_W'(LOCK_TOKENS);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);

    rx_state_e         state_q, state_d;
    logic [WIN_W-1:0]  win_q,   win_d;
    logic [TOK_W-1:0]  tok_q,   tok_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;
    logic [3:0]        slips_q, slips_d;
    logic              bitslip_q, bitslip_d;
    logic              locked_q,  locked_d;
    tmds_dec_t         out_q,     out_d;

    logic              dec_is_ctrl;
    logic [1:0]        dec_ctrl;
    logic [7:0]        dec_data;

    hdmiext_tmds_decode10 u_decode (
        .raw     (raw),
        .is_ctrl (dec_is_ctrl),
        .ctrl    (dec_ctrl),
        .data    (dec_data)
    );

    // Alignment FSM: count tokens per window, slip on a dry window, drop lock on a token-free window
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        tok_d   = tok_q;
        wait_d  = wait_q;
        slips_d = slips_q;
        case (state_q)
            ST_SEARCH: begin
                win_d = win_q + WIN_W'(1);
                if (dec_is_ctrl) begin
                    tok_d = tok_q + TOK_W'(1);
                end
                // A token landing on the last window cycle is counted before the slip decision
                if (dec_is_ctrl && ((tok_q + TOK_W'(1)) == TOK_LOCK)) begin
                    state_d = ST_LOCKED;
                    win_d   = '0;
                    tok_d   = '0;
                end else if (win_q == WIN_LAST) begin
                    state_d = ST_SLIP;
                    win_d   = '0;
                    tok_d   = '0;
                    slips_d = (slips_q == 4'hF) ? slips_q : slips_q + 4'd1;
                end
            end
            ST_SLIP: begin
                state_d = ST_WAIT;
                wait_d  = '0;
            end
            ST_WAIT: begin
                // Deserializer is re-settling; raw is ignored here
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_SEARCH;
                    win_d   = '0;
                    tok_d   = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (dec_is_ctrl) begin
                    win_d = '0;
                end else if (win_q == WIN_LAST) begin
                    // Alignment lost: resume searching without slipping first
                    state_d = ST_SEARCH;
                    win_d   = '0;
                    tok_d   = '0;
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Output word: decoded while the next state is LOCKED, otherwise forced to zero
    always_comb begin
        locked_d  = (state_d == ST_LOCKED);
        bitslip_d = (state_d == ST_SLIP);
        out_d     = '0;
        if (locked_d) begin
            out_d.de = ~dec_is_ctrl;
            if (dec_is_ctrl) begin
                out_d.ctrl = dec_ctrl;
            end else begin
                out_d.data = dec_data;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            state_q   <= ST_SEARCH;
            win_q     <= '0;
            tok_q     <= '0;
            wait_q    <= '0;
            slips_q   <= '0;
            bitslip_q <= 1'b0;
            locked_q  <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            tok_q     <= tok_d;
            wait_q    <= wait_d;
            slips_q   <= slips_d;
            bitslip_q <= bitslip_d;
            locked_q  <= locked_d;
            out_q     <= out_d;
        end
    end

    assign bitslip    = bitslip_q;
    assign locked     = locked_q;
    assign de         = out_q.de;
    assign ctrl       = out_q.ctrl;
    assign data       = out_q.data;
    assign slip_count = slips_q;

endmodule
